// File: rtl/datapath_checker_pkg.sv
// Shared definitions for the datapath checker: opcode encodings, FSM states
// and the "no error seen" index sentinel.
package datapath_checker_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/datapath_golden.sv
// Combinational reference model of the ALU under test; produces the result
// and carry/flag that a correct DUT must return for a given opcode.
module datapath_golden
  import datapath_checker_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  output logic [N-1:0] y_o,
  output logic         co_o
);

  logic [N:0] wide;

  // Add and subtract run one bit wider so bit N holds carry or borrow.
  always_comb begin
    wide = '0;
    y_o  = '0;
    co_o = 1'b0;
    unique case (opcode_i)
      OP_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i};
        y_o  = wide[N-1:0];
        co_o = wide[N];
      end
      OP_SUB: begin
        wide = {1'b0, a_i} - {1'b0, b_i};
        y_o  = wide[N-1:0];
        co_o = wide[N];
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_NOT: y_o = ~a_i;
      OP_SHL: begin
        y_o  = {a_i[N-2:0], 1'b0};
        co_o = a_i[N-1];
      end
      OP_SRA: begin
        y_o  = {a_i[N-1], a_i[N-1:1]};
        co_o = a_i[0];
      end
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/datapath_checker.sv
// Run-based checker: predicts each issued vector's result, delays it to line
// up with the DUT's latency, compares and reports errors per run.
module datapath_checker
  import datapath_checker_pkg::*;
#(
  parameter int N    = 16,
  parameter int pipe = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [15:0]  n_vectors_i,
  input  logic         in_valid_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  input  logic [N-1:0] y_i,
  input  logic         co_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic         mismatch_o,
  output logic [15:0]  err_count_o,
  output logic [15:0]  first_err_idx_o
);

  logic [N-1:0] gold_y;
  logic         gold_co;

  datapath_golden #(.N(N)) u_golden (
    .a_i      (a_i),
    .b_i      (b_i),
    .opcode_i (opcode_i),
    .y_o      (gold_y),
    .co_o     (gold_co)
  );

  state_e      state_q;
  logic [15:0] nvec_q;
  logic [15:0] issued_q;
  logic [15:0] cmp_cnt_q;
  logic [15:0] err_q;
  logic [15:0] first_q;
  logic [N:0]  exp_q [pipe];
  logic        vld_q [pipe];

  logic issue;
  logic cmp_valid;
  logic cmp_fail;
  logic last_cmp;

  assign issue     = (state_q == S_RUN) && in_valid_i && (issued_q != nvec_q);
  assign cmp_valid = (state_q == S_RUN) && vld_q[pipe-1];
  assign cmp_fail  = cmp_valid && ({y_i, co_i} != exp_q[pipe-1]);
  assign last_cmp  = cmp_valid && (cmp_cnt_q == nvec_q - 16'd1);

  // Expected-value payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    exp_q[0] <= {gold_y, gold_co};
    for (int i = 1; i < pipe; i++) begin
      exp_q[i] <= exp_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      nvec_q    <= '0;
      issued_q  <= '0;
      cmp_cnt_q <= '0;
      err_q     <= '0;
      first_q   <= NO_ERR_IDX;
      for (int i = 0; i < pipe; i++) begin
        vld_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= issue;
      for (int i = 1; i < pipe; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            nvec_q    <= n_vectors_i;
            issued_q  <= '0;
            cmp_cnt_q <= '0;
            err_q     <= '0;
            first_q   <= NO_ERR_IDX;
            for (int i = 0; i < pipe; i++) begin
              vld_q[i] <= 1'b0;
            end
            state_q <= (n_vectors_i == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            issued_q <= issued_q + 16'd1;
          end
          if (cmp_valid) begin
            cmp_cnt_q <= cmp_cnt_q + 16'd1;
          end
          if (cmp_fail) begin
            if (err_q != 16'hFFFF) begin
              err_q <= err_q + 16'd1;
            end
            if (first_q == NO_ERR_IDX) begin
              first_q <= cmp_cnt_q;
            end
          end
          if (last_cmp) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = (state_q == S_RUN);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = (state_q == S_DONE) && (err_q == 16'd0);
  assign mismatch_o      = cmp_fail;
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_datapath_checker.sv
// Directed bench for datapath_checker: one checker at latency 2 and one at
// latency 4 share stimulus; the active one is selected per test.
module tb_datapath_checker;
  import datapath_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_vectors = '0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  opcode = '0;
  logic [15:0] y = '0;
  logic        co_in = 1'b0;
  logic        sel4 = 1'b0;

  logic        busy2, done2, pass2, mis2;
  logic [15:0] err2, first2;
  logic        busy4, done4, pass4, mis4;
  logic [15:0] err4, first4;

  logic        busy, done, pass, mismatch;
  logic [15:0] err_count, first_err_idx;

  int errors = 0;
  int checks = 0;

  logic [15:0] vA [8];
  logic [15:0] vB [8];
  logic [2:0]  vOp [8];
  logic [15:0] vY [8];
  logic        vCo [8];
  logic [1:0]  vBad [8];

  always #5 clk = ~clk;

  datapath_checker #(.N(16), .pipe(2)) dut2 (
    .clk_i (clk), .rst_i (rst), .start_i (start), .n_vectors_i (n_vectors),
    .in_valid_i (in_valid), .a_i (a), .b_i (b), .opcode_i (opcode),
    .y_i (y), .co_i (co_in), .busy_o (busy2), .done_o (done2),
    .pass_o (pass2), .mismatch_o (mis2), .err_count_o (err2),
    .first_err_idx_o (first2)
  );

  datapath_checker #(.N(16), .pipe(4)) dut4 (
    .clk_i (clk), .rst_i (rst), .start_i (start), .n_vectors_i (n_vectors),
    .in_valid_i (in_valid), .a_i (a), .b_i (b), .opcode_i (opcode),
    .y_i (y), .co_i (co_in), .busy_o (busy4), .done_o (done4),
    .pass_o (pass4), .mismatch_o (mis4), .err_count_o (err4),
    .first_err_idx_o (first4)
  );

  assign busy          = sel4 ? busy4  : busy2;
  assign done          = sel4 ? done4  : done2;
  assign pass          = sel4 ? pass4  : pass2;
  assign mismatch      = sel4 ? mis4   : mis2;
  assign err_count     = sel4 ? err4   : err2;
  assign first_err_idx = sel4 ? first4 : first2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setVec(input int idx, input logic [2:0] op, input logic [15:0] va,
                        input logic [15:0] vb, input logic [15:0] vy,
                        input logic vco, input logic [1:0] bad);
    vOp[idx]  = op;
    vA[idx]   = va;
    vB[idx]   = vb;
    vY[idx]   = vy;
    vCo[idx]  = vco;
    vBad[idx] = bad;
  endtask

  task automatic checkReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_mismatch", mismatch, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_first_err_idx", first_err_idx, 32'hFFFF);
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    checkReset();
    tick();
    rst = 1'b0;
  endtask

  // Starts a run, issues nIssue vectors back to back and returns each one's
  // DUT result exactly pipe cycles later, corrupting Y/co where vBad says so.
  task automatic applyStimulus(input int nvec, input int nIssue);
    int p;
    int expErr;
    logic expMis;
    p = sel4 ? 4 : 2;
    expErr = 0;
    start = 1'b1;
    n_vectors = nvec[15:0];
    tick();
    start = 1'b0;
    for (int k = 0; k < nIssue + p; k++) begin
      in_valid = (k < nIssue);
      if (k < nIssue) begin
        a = vA[k];
        b = vB[k];
        opcode = vOp[k];
      end
      expMis = 1'b0;
      if (k >= p && k - p < nIssue) begin
        y = vY[k-p] ^ {15'd0, vBad[k-p][0]};
        co_in = vCo[k-p] ^ vBad[k-p][1];
        expMis = (k - p < nvec) && (vBad[k-p] != 2'b00);
      end
      @(negedge clk);
      checkOutput("mismatch", mismatch, expMis);
      checkOutput("err_count_run", err_count, expErr);
      if (k - p < nvec) checkOutput("busy_run", busy, 1);
      if (expMis) expErr++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic checkEnd(input logic expPass, input int expErr, input logic [15:0] expFirst);
    @(negedge clk);
    checkOutput("done", done, 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("pass", pass, expPass);
    checkOutput("err_count", err_count, expErr);
    checkOutput("first_err_idx", first_err_idx, expFirst);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    doReset();

    setVec(0, OP_ADD, 16'd100, 16'd27, 16'd127, 1'b0, 2'b00);
    applyStimulus(1, 1);
    checkEnd(1'b1, 0, 16'hFFFF);

    setVec(0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2'b00);
    setVec(1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 2'b00);
    applyStimulus(2, 2);
    checkEnd(1'b1, 0, 16'hFFFF);

    setVec(0, OP_AND, 16'h00F0, 16'h0F0F, 16'h0000, 1'b0, 2'b00);
    setVec(1, OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 2'b01);
    setVec(2, OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 2'b00);
    applyStimulus(3, 3);
    checkEnd(1'b0, 1, 16'd1);

    setVec(0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 2'b10);
    applyStimulus(1, 1);
    checkEnd(1'b0, 1, 16'd0);

    start = 1'b1;
    n_vectors = 16'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_pass", pass, 1);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_err_count", err_count, 0);
    tick();

    setVec(0, OP_SHL, 16'h8001, 16'h0000, 16'h0002, 1'b1, 2'b00);
    setVec(1, OP_SRA, 16'h8002, 16'h0000, 16'hC001, 1'b0, 2'b00);
    setVec(2, OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 2'b00);
    setVec(3, OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2'b01);
    applyStimulus(3, 4);
    checkEnd(1'b1, 0, 16'hFFFF);

    setVec(0, OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0, 2'b00);
    setVec(1, OP_ADD, 16'd3, 16'd4, 16'd7, 1'b0, 2'b00);
    applyStimulus(5, 2);
    doReset();

    setVec(0, OP_SUB, 16'd5, 16'd3, 16'd2, 1'b0, 2'b00);
    applyStimulus(1, 1);
    checkEnd(1'b1, 0, 16'hFFFF);

    sel4 = 1'b1;
    doReset();
    setVec(0, OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0, 2'b00);
    setVec(1, OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 2'b00);
    setVec(2, OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 2'b00);
    setVec(3, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 2'b00);
    setVec(4, OP_AND, 16'hAAAA, 16'h0FF0, 16'h0AA0, 1'b0, 2'b00);
    setVec(5, OP_XOR, 16'h5A5A, 16'hFFFF, 16'hA5A5, 1'b0, 2'b00);
    setVec(6, OP_SHL, 16'h4000, 16'h0000, 16'h8000, 1'b0, 2'b00);
    setVec(7, OP_SRA, 16'h0003, 16'h0000, 16'h0001, 1'b1, 2'b00);
    applyStimulus(8, 8);
    checkEnd(1'b1, 0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
